// File: rtl/common_pkg.sv
// Shared core types: warp sequencing states, instruction-memory address and data widths.
package common_pkg;

  localparam int INSTR_W          = 32;
  localparam int INSTR_MEM_ADDR_W = 8;
  localparam int DATA_W           = 8;

  typedef logic [INSTR_MEM_ADDR_W-1:0] instr_mem_addr_t;
  typedef logic [DATA_W-1:0]           data_t;

  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_REQUEST = 3'd3,
    WARP_WAIT    = 3'd4,
    WARP_EXECUTE = 3'd5,
    WARP_UPDATE  = 3'd6,
    WARP_DONE    = 3'd7
  } warp_state_t;

endpackage

// File: rtl/warp_controller.sv
// Per-core warp sequencer: fetch, decode, register request, memory wait, execute, PC update.
// Owns the warp PC, the latched instruction word and the retired-instruction counter.
module warp_controller
  import common_pkg::*;
#(
  parameter int INSTR_ADDR_W = 8,
  parameter int THREADS      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [INSTR_ADDR_W-1:0] start_pc,
  output logic                    fetch_req,
  output logic [INSTR_ADDR_W-1:0] fetch_addr,
  input  logic                    fetch_valid,
  input  logic [INSTR_W-1:0]      fetch_instr,
  output logic [INSTR_W-1:0]      instr,
  input  logic                    dec_ret,
  input  logic                    dec_branch,
  input  logic [INSTR_ADDR_W-1:0] branch_target,
  input  logic [THREADS-1:0]      lsu_busy,
  output warp_state_t             warp_state,
  output logic [INSTR_ADDR_W-1:0] pc,
  output logic                    done,
  output logic [15:0]             instr_count
);

  warp_state_t state_q, state_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WARP_IDLE, WARP_DONE: if (start)       state_d = WARP_FETCH;
      WARP_FETCH:           if (fetch_valid) state_d = WARP_DECODE;
      WARP_DECODE:                           state_d = WARP_REQUEST;
      WARP_REQUEST:                          state_d = WARP_WAIT;
      WARP_WAIT:            if (!(|lsu_busy)) state_d = WARP_EXECUTE;
      WARP_EXECUTE:                          state_d = WARP_UPDATE;
      WARP_UPDATE:          state_d = dec_ret ? WARP_DONE : WARP_FETCH;
      default:                               state_d = WARP_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WARP_IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        WARP_IDLE, WARP_DONE: begin
          if (start) begin
            pc          <= start_pc;
            instr_count <= '0;
          end
        end
        WARP_FETCH: begin
          if (fetch_valid) instr <= fetch_instr;
        end
        WARP_UPDATE: begin
          if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
          // RET leaves the PC on the returning instruction.
          if (!dec_ret) begin
            if (dec_branch) pc <= branch_target;
            else            pc <= pc + INSTR_ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only.
  assign warp_state = state_q;
  assign fetch_req  = (state_q == WARP_FETCH);
  assign done       = (state_q == WARP_DONE);
  assign fetch_addr = pc;

endmodule

// File: tb/tb_warp_controller.sv
// Directed, table-driven bench for warp_controller plus hand sequences for stalls and reset.
module tb_warp_controller;
  import common_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  start_pc;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] instr;
  logic        dec_ret;
  logic        dec_branch;
  logic [7:0]  branch_target;
  logic [3:0]  lsu_busy;
  warp_state_t warp_state;
  logic [7:0]  pc;
  logic        done;
  logic [15:0] instr_count;

  warp_controller #(.INSTR_ADDR_W(8), .THREADS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr), .instr(instr), .dec_ret(dec_ret), .dec_branch(dec_branch),
    .branch_target(branch_target), .lsu_busy(lsu_busy), .warp_state(warp_state),
    .pc(pc), .done(done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [7:0]  spc;
    logic        fv;
    logic [31:0] fi;
    logic        ret;
    logic        br;
    logic [7:0]  tgt;
    logic [3:0]  busy;
    warp_state_t st;
    logic [7:0]  pc;
    logic [15:0] cnt;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [7:0] spc, input logic fv,
                              input logic [31:0] fi, input logic ret, input logic br,
                              input logic [7:0] tgt, input logic [3:0] busy,
                              input warp_state_t st, input logic [7:0] pc_e,
                              input logic [15:0] cnt_e, input logic [31:0] ins_e);
    vec_t v;
    v.start = s;  v.spc = spc; v.fv = fv;   v.fi = fi;  v.ret = ret; v.br = br;
    v.tgt = tgt;  v.busy = busy; v.st = st; v.pc = pc_e; v.cnt = cnt_e; v.ins = ins_e;
    return v;
  endfunction

  task automatic check_outputs(input string tag, input warp_state_t st, input logic [7:0] pc_e,
                               input logic [15:0] cnt_e, input logic [31:0] ins_e);
    check({tag, ".state"},      32'(warp_state), 32'(st));
    check({tag, ".pc"},         32'(pc), 32'(pc_e));
    check({tag, ".fetch_addr"}, 32'(fetch_addr), 32'(pc_e));
    check({tag, ".count"},      32'(instr_count), 32'(cnt_e));
    check({tag, ".instr"},      instr, ins_e);
    check({tag, ".fetch_req"},  32'(fetch_req), 32'(st == WARP_FETCH));
    check({tag, ".done"},       32'(done), 32'(st == WARP_DONE));
  endtask

  // Drive one cycle of inputs, clock once, check the registered result.
  task automatic step(input string tag, input vec_t v);
    start = v.start; start_pc = v.spc; fetch_valid = v.fv; fetch_instr = v.fi;
    dec_ret = v.ret; dec_branch = v.br; branch_target = v.tgt; lsu_busy = v.busy;
    @(posedge clk);
    #1;
    check_outputs(tag, v.st, v.pc, v.cnt, v.ins);
  endtask

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask

  // Six rows for one instruction with an immediate fetch and idle LSUs.
  task automatic add_instr(input logic [7:0] p, input logic [15:0] c, input logic [31:0] w,
                           input logic ret, input logic br, input logic [7:0] tgt,
                           input logic [7:0] npc);
    add(mk(0, 0, 1, w, 0, 0, 0, 0, WARP_DECODE,  p, c, w));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, WARP_REQUEST, p, c, w));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, WARP_WAIT,    p, c, w));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, WARP_EXECUTE, p, c, w));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, WARP_UPDATE,  p, c, w));
    add(mk(0, 0, 0, 0, ret, br, tgt, 0, ret ? WARP_DONE : WARP_FETCH, npc, c + 16'd1, w));
  endtask

  initial begin
    // Straight-line run from 0x10: three plain instructions then RET.
    add(mk(0, 8'h33, 1, 32'hAAAA_0000, 0, 0, 0, 4'hF, WARP_IDLE, 8'h00, 0, 0));
    add(mk(1, 8'h10, 0, 0, 0, 0, 0, 0, WARP_FETCH, 8'h10, 0, 0));
    add_instr(8'h10, 0, 32'h1000_0001, 0, 0, 8'h00, 8'h11);
    add_instr(8'h11, 1, 32'h1000_0002, 0, 0, 8'h00, 8'h12);
    add_instr(8'h12, 2, 32'h1000_0003, 0, 0, 8'h00, 8'h13);
    add_instr(8'h13, 3, 32'h1000_0004, 1, 0, 8'h00, 8'h13);
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, WARP_DONE, 8'h13, 4, 32'h1000_0004));
    // Relaunch from DONE near the top of the address space: wrap, branch, RET over branch.
    add(mk(1, 8'hFE, 0, 0, 0, 0, 0, 0, WARP_FETCH, 8'hFE, 0, 32'h1000_0004));
    add_instr(8'hFE, 0, 32'h2000_0001, 0, 0, 8'h00, 8'hFF);
    add_instr(8'hFF, 1, 32'h2000_0002, 0, 0, 8'h00, 8'h00);
    add_instr(8'h00, 2, 32'h2000_0003, 0, 1, 8'h05, 8'h05);
    add_instr(8'h05, 3, 32'h2000_0004, 1, 1, 8'h77, 8'h05);

    reset = 1'b1; start = 0; start_pc = 0; fetch_valid = 0; fetch_instr = 0;
    dec_ret = 0; dec_branch = 0; branch_target = 0; lsu_busy = 0;
    #2;
    check_outputs("reset", WARP_IDLE, 8'h00, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) step($sformatf("tbl%0d", i), tbl[i]);

    // Fetch stall: three cycles without fetch_valid, word captured on the valid cycle.
    step("stall_start", mk(1, 8'h20, 0, 0, 0, 0, 0, 0, WARP_FETCH, 8'h20, 0, 32'h2000_0004));
    for (int i = 0; i < 3; i++)
      step($sformatf("stall%0d", i),
           mk(0, 0, 0, 32'hDEAD_0000 + 32'(i), 0, 0, 0, 0, WARP_FETCH, 8'h20, 0, 32'h2000_0004));
    step("stall_valid", mk(0, 0, 1, 32'h1234_5678, 0, 0, 0, 0, WARP_DECODE, 8'h20, 0, 32'h1234_5678));
    step("mw_req",  mk(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, WARP_REQUEST, 8'h20, 0, 32'h1234_5678));
    step("mw_wait", mk(0, 0, 0, 0, 0, 0, 0, 0, WARP_WAIT, 8'h20, 0, 32'h1234_5678));

    // Memory wait with a spurious start on the first busy cycle.
    step("mw_spurious", mk(1, 8'h99, 0, 0, 0, 0, 0, 4'b0101, WARP_WAIT, 8'h20, 0, 32'h1234_5678));
    for (int i = 0; i < 4; i++)
      step($sformatf("mw_busy%0d", i),
           mk(0, 0, 0, 0, 0, 0, 0, 4'b0101, WARP_WAIT, 8'h20, 0, 32'h1234_5678));
    step("mw_clear", mk(0, 0, 0, 0, 0, 0, 0, 4'b0000, WARP_EXECUTE, 8'h20, 0, 32'h1234_5678));
    step("mw_single_exec", mk(0, 0, 0, 0, 0, 0, 0, 4'b0101, WARP_UPDATE, 8'h20, 0, 32'h1234_5678));
    step("mw_update", mk(0, 0, 0, 0, 0, 0, 0, 0, WARP_FETCH, 8'h21, 1, 32'h1234_5678));

    // Reset arriving mid-EXECUTE aborts at once, without waiting for a clock edge.
    step("rst_fetch", mk(0, 0, 1, 32'h3000_0001, 0, 0, 0, 0, WARP_DECODE, 8'h21, 1, 32'h3000_0001));
    step("rst_req",   mk(0, 0, 0, 0, 0, 0, 0, 0, WARP_REQUEST, 8'h21, 1, 32'h3000_0001));
    step("rst_wait",  mk(0, 0, 0, 0, 0, 0, 0, 0, WARP_WAIT, 8'h21, 1, 32'h3000_0001));
    step("rst_exec",  mk(0, 0, 0, 0, 0, 1, 8'h44, 0, WARP_EXECUTE, 8'h21, 1, 32'h3000_0001));
    #3;
    reset = 1'b1;
    #1;
    check_outputs("rst_async", WARP_IDLE, 8'h00, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step("rst_idle_hold", mk(0, 8'h55, 1, 32'h4444_4444, 0, 0, 0, 0, WARP_IDLE, 8'h00, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its end, expected completion");
    $fatal(1);
  end

endmodule
